// File: rtl/lh_pkg.sv
// Shared types and constants for the light-hash message framer.
package lh_pkg;

    localparam logic [7:0] HEAD_BYTE = 8'hFF;
    localparam logic [7:0] TAIL_BYTE = 8'h00;

    // Payload byte ranges; 0xFF and 0x00 stay reserved for framing.
    localparam logic [7:0] LO_RANGE_MIN = 8'h20;
    localparam logic [7:0] LO_RANGE_MAX = 8'h7E;
    localparam logic [7:0] HI_RANGE_MIN = 8'hA1;
    localparam logic [7:0] HI_RANGE_MAX = 8'hFE;

    typedef struct packed {
        logic       last;
        logic       keep;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        GAP,
        BODY,
        TAIL,
        WAIT
    } framer_state_t;

    function automatic logic is_payload_byte(input logic [7:0] b);
        return ((b >= LO_RANGE_MIN) && (b <= LO_RANGE_MAX)) ||
               ((b >= HI_RANGE_MIN) && (b <= HI_RANGE_MAX));
    endfunction

endpackage

// File: rtl/lh_byte_fifo.sv
// Synchronous show-ahead FIFO; rd_data always presents the oldest entry.
module lh_byte_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lh_msg_framer.sv
// Framer feeding the light-hash core: buffers an upstream byte stream, drops
// non-payload bytes and replays each message as HEAD, payload..., TAIL with a
// programmable gap between message_valid pulses.
// Optional: define LH_FRAMER_DROP_CNT_EN to add a saturating drop_count output.
module lh_msg_framer
    import lh_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int MAX_LEN    = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_byte,
    output logic        m_valid,
    input  logic        digest_ready,
    output logic        busy,
    output logic        err_invalid,
    output logic        truncated
`ifdef LH_FRAMER_DROP_CNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam int            LW       = $clog2(MAX_LEN + 1);
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(1);

    fifo_entry_t   wr_entry;
    fifo_entry_t   rd_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          s_fire;
    logic          byte_ok;

    framer_state_t state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [LW-1:0] len_q, len_d;
    logic          trunc_q, trunc_d;
    logic          last_q, last_d;
    logic [7:0]    m_byte_d;
    logic          m_valid_d;
    logic          truncated_d;

    assign s_ready   = rst_n && !fifo_full;
    assign s_fire    = s_valid && s_ready;
    assign byte_ok   = is_payload_byte(s_byte);
    // An invalid final byte is still queued (keep=0) so the message terminates.
    assign fifo_push = s_fire && (byte_ok || s_last);

    // Build the FIFO entry; dropped payload is zeroed since it is never emitted.
    always_comb begin
        wr_entry      = '0;
        wr_entry.last = s_last;
        wr_entry.keep = byte_ok;
        wr_entry.data = byte_ok ? s_byte : 8'h00;
    end

    lh_byte_fifo #(
        .DEPTH (DEPTH),
        .T     (fifo_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state and output decode. Output values are registered, so the
    // decision made in a cycle appears on the pins the following cycle. The
    // gap counter is loaded with the pulse and counts the pulse cycle itself,
    // giving GAP_CYCLES quiet cycles between pulses.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        last_d      = last_q;
        m_byte_d    = m_byte;
        m_valid_d   = 1'b0;
        truncated_d = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = HEAD;
                    m_valid_d = 1'b1;
                    m_byte_d  = HEAD_BYTE;
                    gap_d     = GAP_LOAD;
                end
            end
            HEAD: begin
                len_d   = '0;
                trunc_d = 1'b0;
                last_d  = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = BODY;
                end else begin
                    gap_d   = gap_q - 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = last_q ? TAIL : BODY;
                else                   gap_d   = gap_q - 1'b1;
            end
            BODY: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (rd_entry.last) last_d = 1'b1;
                    if (rd_entry.keep && (len_q < MAX_LEN_C)) begin
                        m_valid_d = 1'b1;
                        m_byte_d  = rd_entry.data;
                        len_d     = len_q + 1'b1;
                        gap_d     = GAP_LOAD;
                        state_d   = GAP;
                    end else begin
                        if (rd_entry.keep) trunc_d = 1'b1;
                        if (rd_entry.last) state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                m_valid_d   = 1'b1;
                m_byte_d    = TAIL_BYTE;
                truncated_d = trunc_q;
                trunc_d     = 1'b0;
                last_d      = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (digest_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset abandons any message.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            last_q      <= 1'b0;
            m_byte      <= 8'h00;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            err_invalid <= 1'b0;
            truncated   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            last_q      <= last_d;
            m_byte      <= m_byte_d;
            m_valid     <= m_valid_d;
            busy        <= (state_d != IDLE);
            err_invalid <= s_fire && !byte_ok;
            truncated   <= truncated_d;
        end
    end

`ifdef LH_FRAMER_DROP_CNT_EN
    logic        inv_drop;
    logic        trunc_drop;
    logic [16:0] drop_sum;

    assign inv_drop   = s_fire && !byte_ok;
    assign trunc_drop = (state_q == BODY) && !fifo_empty && rd_entry.keep &&
                        (len_q == MAX_LEN_C);
    assign drop_sum   = {1'b0, drop_count} + {16'd0, inv_drop} + {16'd0, trunc_drop};

    // Saturating count of dropped invalid and truncated bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) drop_count <= '0;
        else        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_lh_msg_framer.sv
// Directed self-checking bench for lh_msg_framer (DEPTH=16, MAX_LEN=32, GAP_CYCLES=2).
module tb_lh_msg_framer;

    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 32;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_byte = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       digest_ready = 1'b0;
    logic       s_ready;
    logic [7:0] m_byte;
    logic       m_valid;
    logic       busy;
    logic       err_invalid;
    logic       truncated;
`ifdef LH_FRAMER_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] q_b[$];
    int         q_c[$];
    logic       q_t[$];
    int         err_cnt = 0;
    int         tr_cnt = 0;

    lh_msg_framer #(
        .DEPTH      (DEPTH),
        .MAX_LEN    (MAX_LEN),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_byte       (s_byte),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_byte       (m_byte),
        .m_valid      (m_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .err_invalid  (err_invalid),
        .truncated    (truncated)
`ifdef LH_FRAMER_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted pulse with its cycle index, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            q_b.push_back(m_byte);
            q_c.push_back(cyc);
            q_t.push_back(truncated);
        end
        if (err_invalid) err_cnt++;
        if (truncated)   tr_cnt++;
    end

    task automatic clear_mon();
        @(posedge clk);
        q_b.delete();
        q_c.delete();
        q_t.delete();
        err_cnt = 0;
        tr_cnt  = 0;
        @(negedge clk);
    endtask

    // Offer one byte from a negedge until accepted (bounded); returns at a negedge.
    task automatic push(input logic [7:0] b, input logic last, output int acc_cyc);
        logic done;
        done    = 1'b0;
        acc_cyc = -1;
        s_byte  = b;
        s_last  = last;
        s_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (s_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        @(posedge clk);
        while (q_b.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_digest();
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        tests++; if (m_byte !== 8'h00) begin fails++; $display("FAIL reset_m_byte got=%02h exp=00", m_byte); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (err_invalid !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_invalid); end
        tests++; if (truncated !== 1'b0) begin fails++; $display("FAIL reset_trunc got=%b exp=0", truncated); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_abc();
        logic [7:0] exp [5];
        int c0, c;
        exp = '{8'hFF, 8'h61, 8'h62, 8'h63, 8'h00};
        clear_mon();
        push(8'h61, 1'b0, c0);
        push(8'h62, 1'b0, c);
        push(8'h63, 1'b1, c);
        wait_pulses(5, 100);
        tests++; if (q_b.size() != 5) begin fails++; $display("FAIL abc_count got=%0d exp=5", q_b.size()); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= q_b.size() || q_b[i] !== exp[i]) begin
                fails++; $display("FAIL abc_byte[%0d] got=%02h exp=%02h", i, (i < q_b.size()) ? q_b[i] : 8'hxx, exp[i]);
            end
        end
        if (q_b.size() == 5) begin
            tests++; if (q_c[0] - c0 != 2) begin fails++; $display("FAIL abc_head_latency got=%0d exp=2", q_c[0] - c0); end
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_c[i+1] - q_c[i] != GAP + 1) begin
                    fails++; $display("FAIL abc_spacing[%0d] got=%0d exp=%0d", i, q_c[i+1] - q_c[i], GAP + 1);
                end
            end
        end
        repeat (4) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abc_busy_wait got=%b exp=1", busy); end
        pulse_digest();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abc_busy_after_digest got=%b exp=0", busy); end
        tests++; if (q_b.size() != 5) begin fails++; $display("FAIL abc_extra_pulses got=%0d exp=5", q_b.size()); end
    endtask

    task automatic test_invalid();
        logic [7:0] exp [4];
        int c;
        exp = '{8'hFF, 8'h41, 8'h42, 8'h00};
        clear_mon();
        digest_ready = 1'b1;
        push(8'h41, 1'b0, c);
        push(8'h07, 1'b0, c);
        tests++; if (err_invalid !== 1'b1) begin fails++; $display("FAIL inv_err_pulse got=%b exp=1", err_invalid); end
        push(8'h42, 1'b1, c);
        tests++; if (err_invalid !== 1'b0) begin fails++; $display("FAIL inv_err_valid_byte got=%b exp=0", err_invalid); end
        wait_pulses(4, 100);
        repeat (3) @(negedge clk);
        digest_ready = 1'b0;
        tests++; if (q_b.size() != 4) begin fails++; $display("FAIL inv_count got=%0d exp=4", q_b.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= q_b.size() || q_b[i] !== exp[i]) begin
                fails++; $display("FAIL inv_byte[%0d] got=%02h exp=%02h", i, (i < q_b.size()) ? q_b[i] : 8'hxx, exp[i]);
            end
        end
        tests++; if (err_cnt != 1) begin fails++; $display("FAIL inv_err_count got=%0d exp=1", err_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL inv_busy got=%b exp=0", busy); end
    endtask

    task automatic test_truncate();
        int c;
        clear_mon();
        for (int i = 0; i < 40; i++) push(8'h55, (i == 39), c);
        wait_pulses(MAX_LEN + 2, 400);
        repeat (3) @(negedge clk);
        tests++; if (q_b.size() != MAX_LEN + 2) begin fails++; $display("FAIL trunc_count got=%0d exp=%0d", q_b.size(), MAX_LEN + 2); end
        if (q_b.size() == MAX_LEN + 2) begin
            tests++; if (q_b[0] !== 8'hFF) begin fails++; $display("FAIL trunc_head got=%02h exp=FF", q_b[0]); end
            for (int i = 1; i <= MAX_LEN; i++) begin
                tests++;
                if (q_b[i] !== 8'h55) begin fails++; $display("FAIL trunc_payload[%0d] got=%02h exp=55", i, q_b[i]); end
            end
            tests++; if (q_b[MAX_LEN+1] !== 8'h00) begin fails++; $display("FAIL trunc_tail got=%02h exp=00", q_b[MAX_LEN+1]); end
            tests++; if (q_t[MAX_LEN+1] !== 1'b1) begin fails++; $display("FAIL trunc_flag_on_tail got=%b exp=1", q_t[MAX_LEN+1]); end
        end
        tests++; if (tr_cnt != 1) begin fails++; $display("FAIL trunc_pulse_count got=%0d exp=1", tr_cnt); end
        tests++; if (err_cnt != 0) begin fails++; $display("FAIL trunc_err_count got=%0d exp=0", err_cnt); end
        pulse_digest();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [DEPTH+4];
        int acc, c;
        for (int i = 0; i < DEPTH + 4; i++) d[i] = 8'h30 + 8'(i);
        clear_mon();
        push(8'h5A, 1'b1, c);
        wait_pulses(3, 100);
        acc = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            s_byte  = d[acc];
            s_last  = (acc == DEPTH + 3);
            s_valid = 1'b1;
            if (s_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tests++; if (acc != DEPTH) begin fails++; $display("FAIL b2b_accepts got=%0d exp=%0d", acc, DEPTH); end
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL b2b_s_ready_full got=%b exp=0", s_ready); end
        tests++; if (q_b.size() != 3) begin fails++; $display("FAIL b2b_stall_pulses got=%0d exp=3", q_b.size()); end
        pulse_digest();
        for (int i = acc; i < DEPTH + 4; i++) push(d[i], (i == DEPTH + 3), c);
        wait_pulses(3 + DEPTH + 6, 400);
        repeat (3) @(negedge clk);
        tests++; if (q_b.size() != 3 + DEPTH + 6) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", q_b.size(), 3 + DEPTH + 6); end
        if (q_b.size() == 3 + DEPTH + 6) begin
            tests++; if (q_b[3] !== 8'hFF) begin fails++; $display("FAIL b2b_head got=%02h exp=FF", q_b[3]); end
            for (int i = 0; i < DEPTH + 4; i++) begin
                tests++;
                if (q_b[4+i] !== d[i]) begin fails++; $display("FAIL b2b_byte[%0d] got=%02h exp=%02h", i, q_b[4+i], d[i]); end
            end
            tests++; if (q_b[DEPTH+8] !== 8'h00) begin fails++; $display("FAIL b2b_tail got=%02h exp=00", q_b[DEPTH+8]); end
        end
        pulse_digest();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4];
        int c;
        exp = '{8'hFF, 8'h78, 8'h79, 8'h00};
        clear_mon();
        push(8'h41, 1'b0, c);
        push(8'h42, 1'b0, c);
        push(8'h43, 1'b0, c);
        push(8'h44, 1'b0, c);
        push(8'h45, 1'b1, c);
        wait_pulses(3, 100);
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        tests++; if (q_b.size() != 3) begin fails++; $display("FAIL rstmid_no_tail got=%0d exp=3", q_b.size()); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle_busy got=%b exp=0", busy); end
        push(8'h78, 1'b0, c);
        push(8'h79, 1'b1, c);
        wait_pulses(7, 100);
        tests++; if (q_b.size() != 7) begin fails++; $display("FAIL rstmid_count got=%0d exp=7", q_b.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (3 + i >= q_b.size() || q_b[3+i] !== exp[i]) begin
                fails++; $display("FAIL rstmid_byte[%0d] got=%02h exp=%02h", i, (3 + i < q_b.size()) ? q_b[3+i] : 8'hxx, exp[i]);
            end
        end
        pulse_digest();
    endtask

    task automatic test_empty_msg();
        int c;
        clear_mon();
        push(8'h01, 1'b1, c);
        tests++; if (err_invalid !== 1'b1) begin fails++; $display("FAIL empty_err_pulse got=%b exp=1", err_invalid); end
        wait_pulses(2, 100);
        repeat (6) @(negedge clk);
        tests++; if (q_b.size() != 2) begin fails++; $display("FAIL empty_count got=%0d exp=2", q_b.size()); end
        if (q_b.size() == 2) begin
            tests++; if (q_b[0] !== 8'hFF) begin fails++; $display("FAIL empty_head got=%02h exp=FF", q_b[0]); end
            tests++; if (q_b[1] !== 8'h00) begin fails++; $display("FAIL empty_tail got=%02h exp=00", q_b[1]); end
            tests++; if (q_t[1] !== 1'b0) begin fails++; $display("FAIL empty_trunc got=%b exp=0", q_t[1]); end
        end
        tests++; if (err_cnt != 1) begin fails++; $display("FAIL empty_err_count got=%0d exp=1", err_cnt); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL empty_busy_wait got=%b exp=1", busy); end
        pulse_digest();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_abc();
        test_invalid();
        test_truncate();
        test_back_to_back();
        test_reset_mid();
        test_empty_msg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
